apb_nslave_master: RTL and testbench

Parametrised APB master bridge that turns single-cycle `transfer` requests from the testbench/host side into APB3 SETUP/ACCESS sequences toward `NUM_SLAVES` slaves. It is the next generation of the two-slave bridge. It adds:
- address-decoded `psel` fan-out;
- `pready` wait states and `pslverr` error reporting;
- an explicit request/response handshake.

It sits between the host-side stimulus interface and the slave array in the APB subsystem.

---
 rtl/apb_nslave_pkg.sv | 16 +
 rtl/apb_addr_decode.sv | 14 +
 rtl/apb_nslave_master.sv | 119 +++++++++++
 tb/tb_apb_nslave_master.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/apb_nslave_pkg.sv
// apb_nslave_pkg: shared FSM state, request record and default widths for the APB n-slave bridge
`ifndef AW
`define AW 32
`endif
`ifndef DW
`define DW 32
`endif

package apb_nslave_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;
  typedef struct packed {
    logic             pwrite;
    logic [`AW-1:0]   paddr;
    logic [`DW-1:0]   pwdata;
  } apb_req_t;
endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: maps the address MSBs to a slave index, hit flag and one-hot select
module apb_addr_decode #(
  parameter int NUM_SLAVES = 4,
  parameter int SELW = $clog2(NUM_SLAVES)
) (
  input  logic [SELW-1:0]       addr_hi_i,
  output logic [SELW-1:0]       idx_o,
  output logic                  hit_o,
  output logic [NUM_SLAVES-1:0] sel_o
);
  assign idx_o = addr_hi_i;
  assign hit_o = {1'b0, idx_o} < (SELW+1)'(NUM_SLAVES);
  assign sel_o = hit_o ? NUM_SLAVES'(1) << idx_o : '0;
endmodule

// File: rtl/apb_nslave_master.sv
// apb_nslave_master: host-to-APB3 bridge with decoded psel, wait states and error reporting.
// Define APB_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT_CYCLES wait cycles.
module apb_nslave_master
  import apb_nslave_pkg::*;
#(
  parameter int AW = `AW,
  parameter int DW = `DW,
  parameter int NUM_SLAVES = 4,
  parameter int SELW = $clog2(NUM_SLAVES),
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     transfer,
  input  logic                     read_write,
  input  logic [AW-1:0]            apb_write_paddr,
  input  logic [DW-1:0]            apb_write_data,
  input  logic [AW-1:0]            apb_read_paddr,
  output logic                     req_ready,
  output logic [DW-1:0]            apb_read_data_out,
  output logic                     rsp_valid,
  output logic                     rsp_error,
  output logic [NUM_SLAVES-1:0]    psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [AW-1:0]            paddr,
  output logic [DW-1:0]            pwdata,
  input  logic [NUM_SLAVES*DW-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]    pready,
  input  logic [NUM_SLAVES-1:0]    pslverr
);
  apb_state_e state_q, state_d;
  apb_req_t req_q, req_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d, dec_sel;
  logic [SELW-1:0] idx_q, idx_d, dec_idx;
  logic [DW-1:0] rdata_q, rdata_d;
  logic err_q, err_d, dec_hit, rdy, slverr, tmo;
  logic [AW-1:0] in_addr;

  assign in_addr = read_write ? apb_read_paddr : apb_write_paddr;
  assign rdy     = pready[idx_q];
  assign slverr  = pslverr[idx_q];

  apb_addr_decode #(.NUM_SLAVES(NUM_SLAVES), .SELW(SELW)) u_dec (
    .addr_hi_i(in_addr[AW-1 -: SELW]),
    .idx_o    (dec_idx),
    .hit_o    (dec_hit),
    .sel_o    (dec_sel)
  );

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES+1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge pclk) begin
    if (preset || state_q != ACCESS) cnt_q <= '0;
    else if (!rdy) cnt_q <= cnt_q + 1'b1;
  end
  // this wait cycle is the one that brings the count to TIMEOUT_CYCLES
  assign tmo = cnt_q == CW'(TIMEOUT_CYCLES-1);
`else
  assign tmo = TIMEOUT_CYCLES < 0;
`endif

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      req_q   <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (transfer) begin
        req_d   = '{pwrite: !read_write, paddr: in_addr, pwdata: apb_write_data};
        sel_d   = dec_sel;
        idx_d   = dec_idx;
        err_d   = !dec_hit;
        state_d = dec_hit ? SETUP : RESP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: if (rdy) begin
        err_d   = slverr;
        rdata_d = (!req_q.pwrite && !slverr) ? prdata[idx_q*DW +: DW] : rdata_q;
        state_d = RESP;
      end else if (tmo) begin
        err_d   = 1'b1;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready         = state_q == IDLE && !preset;
  assign psel              = (state_q == SETUP || state_q == ACCESS) ? sel_q : '0;
  assign penable           = state_q == ACCESS;
  assign pwrite            = req_q.pwrite;
  assign paddr             = req_q.paddr;
  assign pwdata            = req_q.pwdata;
  assign rsp_valid         = state_q == RESP;
  assign rsp_error         = rsp_valid && err_q;
  assign apb_read_data_out = rdata_q;
endmodule

// File: tb/tb_apb_nslave_master.sv
// tb_apb_nslave_master: directed checks of the APB n-slave bridge, 4-slave and 3-slave builds
module tb_apb_nslave_master;
  logic pclk = 1'b0, preset = 1'b1;
  logic transfer = 1'b0, transfer3 = 1'b0, read_write = 1'b0;
  logic [31:0] waddr = '0, raddr = '0, wdata = '0;
  logic req_ready, rsp_valid, rsp_error, penable, pwrite;
  logic [3:0] psel, pready = '0, pslverr = '0;
  logic [31:0] paddr, pwdata, rdata;
  logic [127:0] prdata = '0;
  logic req_ready3, rsp_valid3, rsp_error3, penable3, pwrite3;
  logic [2:0] psel3, pready3 = 3'b111, pslverr3 = '0;
  logic [31:0] paddr3, pwdata3, rdata3;
  logic [95:0] prdata3 = '0;
  int tests = 0, fails = 0;

  always #5 pclk = ~pclk;

  apb_nslave_master #(.AW(32), .DW(32), .NUM_SLAVES(4), .TIMEOUT_CYCLES(16)) u4 (
    .pclk(pclk), .preset(preset), .transfer(transfer), .read_write(read_write),
    .apb_write_paddr(waddr), .apb_write_data(wdata), .apb_read_paddr(raddr),
    .req_ready(req_ready), .apb_read_data_out(rdata), .rsp_valid(rsp_valid), .rsp_error(rsp_error),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  apb_nslave_master #(.AW(32), .DW(32), .NUM_SLAVES(3), .TIMEOUT_CYCLES(16)) u3 (
    .pclk(pclk), .preset(preset), .transfer(transfer3), .read_write(read_write),
    .apb_write_paddr(waddr), .apb_write_data(wdata), .apb_read_paddr(raddr),
    .req_ready(req_ready3), .apb_read_data_out(rdata3), .rsp_valid(rsp_valid3), .rsp_error(rsp_error3),
    .psel(psel3), .penable(penable3), .pwrite(pwrite3), .paddr(paddr3), .pwdata(pwdata3),
    .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
  );

  // the unused address port carries a decoy so the read/write address mux is exercised
  task automatic issue(input logic rw, input logic [31:0] a, input logic [31:0] d);
    @(negedge pclk);
    read_write = rw;
    waddr = rw ? 32'h5555_0000 : a;
    raddr = rw ? a : 32'hAAAA_0000;
    wdata = d;
    transfer = 1'b1;
    @(posedge pclk);
    #1 transfer = 1'b0;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (2) @(negedge pclk);
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
    tests++; if (psel !== 4'h0 || penable !== 1'b0) begin fails++; $display("FAIL rst_psel_penable got %b/%b want 0000/0", psel, penable); end
    tests++; if (rsp_valid !== 1'b0 || rsp_error !== 1'b0) begin fails++; $display("FAIL rst_rsp got %b/%b want 0/0", rsp_valid, rsp_error); end
    tests++; if (paddr !== 32'h0 || pwdata !== 32'h0 || pwrite !== 1'b0 || rdata !== 32'h0) begin fails++; $display("FAIL rst_regs got %h %h %b %h want zeros", paddr, pwdata, pwrite, rdata); end
    preset = 1'b0;
    @(negedge pclk);
    tests++; if (req_ready !== 1'b1 || req_ready3 !== 1'b1) begin fails++; $display("FAIL rst_release_ready got %b/%b want 1/1", req_ready, req_ready3); end
  endtask

  task automatic test_zero_wait_write();
    pready = 4'b0010;
    pslverr = 4'b1101;
    issue(1'b0, 32'h4000_0010, 32'hDEAD_BEEF);
    @(negedge pclk);
    tests++; if (psel !== 4'b0010 || penable !== 1'b0) begin fails++; $display("FAIL zw_setup got %b/%b want 0010/0", psel, penable); end
    tests++; if (paddr !== 32'h4000_0010 || pwdata !== 32'hDEAD_BEEF || pwrite !== 1'b1) begin fails++; $display("FAIL zw_bus got %h %h %b want 40000010 deadbeef 1", paddr, pwdata, pwrite); end
    tests++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL zw_busy got %b/%b want 0/0", req_ready, rsp_valid); end
    @(negedge pclk);
    tests++; if (psel !== 4'b0010 || penable !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL zw_access got %b/%b/%b want 0010/1/0", psel, penable, rsp_valid); end
    @(negedge pclk);
    tests++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0) begin fails++; $display("FAIL zw_resp got %b/%b want 1/0", rsp_valid, rsp_error); end
    tests++; if (psel !== 4'h0 || penable !== 1'b0 || req_ready !== 1'b0) begin fails++; $display("FAIL zw_resp_bus got %b/%b/%b want 0000/0/0", psel, penable, req_ready); end
    tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL zw_rdata_kept got %h want 0", rdata); end
    @(negedge pclk);
    tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL zw_idle got %b/%b want 0/1", rsp_valid, req_ready); end
    pslverr = '0;
  endtask

  task automatic test_read_waits();
    pready = 4'b0111;
    prdata[127:96] = 32'h1234_5678;
    issue(1'b1, 32'hC000_0004, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge pclk);
      if (k == 1) begin
        tests++; if (psel !== 4'b1000 || penable !== 1'b0 || pwrite !== 1'b0 || paddr !== 32'hC000_0004) begin fails++; $display("FAIL rw_setup got %b/%b/%b/%h want 1000/0/0/c0000004", psel, penable, pwrite, paddr); end
      end
      if (k >= 2 && k <= 5) begin
        tests++; if (penable !== 1'b1 || rsp_valid !== 1'b0 || paddr !== 32'hC000_0004) begin fails++; $display("FAIL rw_wait%0d got %b/%b/%h want 1/0/c0000004", k, penable, rsp_valid, paddr); end
      end
      if (k == 5) pready = 4'b1000;
      if (k == 6) begin
        tests++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0) begin fails++; $display("FAIL rw_resp got %b/%b want 1/0", rsp_valid, rsp_error); end
        tests++; if (rdata !== 32'h1234_5678) begin fails++; $display("FAIL rw_rdata got %h want 12345678", rdata); end
      end
    end
    pready = '0;
  endtask

  task automatic test_slave_error();
    prdata[95:64] = 32'hAAAA_5555;
    pready = 4'b0100;
    pslverr = 4'b0100;
    issue(1'b1, 32'h8000_0000, 32'h0);
    @(negedge pclk);
    tests++; if (psel !== 4'b0100) begin fails++; $display("FAIL se_psel got %b want 0100", psel); end
    repeat (2) @(negedge pclk);
    tests++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1) begin fails++; $display("FAIL se_resp got %b/%b want 1/1", rsp_valid, rsp_error); end
    tests++; if (rdata !== 32'h1234_5678) begin fails++; $display("FAIL se_rdata_kept got %h want 12345678", rdata); end
    pready = '0;
    pslverr = '0;
    @(negedge pclk);
  endtask

  task automatic test_decode_miss();
    @(negedge pclk);
    read_write = 1'b0;
    waddr = 32'hC000_0000;
    wdata = 32'h0000_0001;
    transfer3 = 1'b1;
    @(posedge pclk);
    #1 transfer3 = 1'b0;
    @(negedge pclk);
    tests++; if (rsp_valid3 !== 1'b1 || rsp_error3 !== 1'b1) begin fails++; $display("FAIL dm_resp got %b/%b want 1/1", rsp_valid3, rsp_error3); end
    tests++; if (psel3 !== 3'b000 || penable3 !== 1'b0) begin fails++; $display("FAIL dm_psel got %b/%b want 000/0", psel3, penable3); end
    @(negedge pclk);
    tests++; if (rsp_valid3 !== 1'b0 || psel3 !== 3'b000 || req_ready3 !== 1'b1) begin fails++; $display("FAIL dm_idle got %b/%b/%b want 0/000/1", rsp_valid3, psel3, req_ready3); end
    tests++; if (rsp_valid !== 1'b0 || psel !== 4'h0) begin fails++; $display("FAIL dm_other_idle got %b/%b want 0/0000", rsp_valid, psel); end
  endtask

  task automatic test_timeout();
    int first = 0;
    pready = '0;
    issue(1'b0, 32'h0000_0100, 32'h0000_0011);
`ifdef APB_TIMEOUT_EN
    for (int k = 1; k <= 18; k++) begin
      @(negedge pclk);
      if (rsp_valid === 1'b1 && first == 0) first = k;
      if (k == 18) begin
        tests++; if (rsp_error !== 1'b1 || rdata !== 32'h1234_5678) begin fails++; $display("FAIL to_resp got err %b rdata %h want 1 12345678", rsp_error, rdata); end
      end
    end
    tests++; if (first != 18) begin fails++; $display("FAIL to_latency got cycle %0d want 18", first); end
    @(negedge pclk);
`else
    for (int k = 1; k <= 100; k++) begin
      @(negedge pclk);
      if (rsp_valid === 1'b1) first++;
    end
    tests++; if (first != 0) begin fails++; $display("FAIL to_no_resp got %0d responses want 0", first); end
    tests++; if (penable !== 1'b1 || psel !== 4'b0001) begin fails++; $display("FAIL to_still_access got %b/%b want 1/0001", penable, psel); end
    preset = 1'b1;
    @(negedge pclk);
    tests++; if (psel !== 4'h0 || penable !== 1'b0 || rdata !== 32'h0) begin fails++; $display("FAIL to_reset got %b/%b/%h want 0000/0/0", psel, penable, rdata); end
    preset = 1'b0;
    @(negedge pclk);
    prdata[31:0] = 32'h0;
`endif
  endtask

  task automatic test_reset_mid_access();
    pready = '0;
    issue(1'b1, 32'h4000_0008, 32'h0000_0077);
    @(negedge pclk);
    tests++; if (psel !== 4'b0010 || pwdata !== 32'h0000_0077) begin fails++; $display("FAIL rm_setup got %b/%h want 0010/00000077", psel, pwdata); end
    @(negedge pclk);
    tests++; if (penable !== 1'b1) begin fails++; $display("FAIL rm_access got %b want 1", penable); end
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    tests++; if (psel !== 4'h0 || penable !== 1'b0 || pwrite !== 1'b0) begin fails++; $display("FAIL rm_ctrl got %b/%b/%b want 0000/0/0", psel, penable, pwrite); end
    tests++; if (paddr !== 32'h0 || pwdata !== 32'h0) begin fails++; $display("FAIL rm_bus got %h/%h want 0/0", paddr, pwdata); end
    tests++; if (rsp_valid !== 1'b0 || rsp_error !== 1'b0 || req_ready !== 1'b0) begin fails++; $display("FAIL rm_rsp got %b/%b/%b want 0/0/0", rsp_valid, rsp_error, req_ready); end
    tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL rm_rdata got %h want 0", rdata); end
    preset = 1'b0;
    @(negedge pclk);
    tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL rm_idle got %b/%b want 1/0", req_ready, rsp_valid); end
    prdata[63:32] = 32'h0BAD_F00D;
    pready = 4'b0010;
    issue(1'b1, 32'h4000_0008, 32'h0);
    repeat (2) @(negedge pclk);
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rm_new_early got %b want 0", rsp_valid); end
    @(negedge pclk);
    tests++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rdata !== 32'h0BAD_F00D) begin fails++; $display("FAIL rm_new_resp got %b/%b/%h want 1/0/0badf00d", rsp_valid, rsp_error, rdata); end
    pready = '0;
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_read_waits();
    test_slave_error();
    test_decode_miss();
    test_timeout();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
